// File: rtl/iter_counter_pkg.sv
// Shared definitions for the iteration counter and the mult/div controllers
// that reuse its state encoding.
package iter_counter_pkg;

    // Default counter/limit width; max iterations = 2**WIDTH-1.
    localparam int unsigned DEFAULT_WIDTH = 6;

    // Sequencer states. Encoding is fixed so other controllers can share it;
    // 2'd3 is illegal and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // States in which a new operation may be accepted.
    function automatic logic can_accept(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage : iter_counter_pkg

// File: rtl/iter_counter_updn_counter.sv
// WIDTH-bit up/down counter with async clear, enable, synchronous load
// and an inc/dec step select. Load has priority over step.
module updn_counter
    import iter_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             step,
    input  logic             down,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_stepped;

    // Next value when stepping: decrement in down mode, else increment.
    always_comb begin
        count_stepped = count;
        if (down) begin
            count_stepped = count - WIDTH'(1);
        end else begin
            count_stepped = count + WIDTH'(1);
        end
    end

    // Count register: load wins over step; everything frozen when ena=0.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
        end else if (ena) begin
            if (load) begin
                count <= value;
            end else if (step) begin
                count <= count_stepped;
            end
        end
    end

endmodule : updn_counter

// File: rtl/iter_counter.sv
// Iteration counter/sequencer: runs a programmable number of iterations per
// operation counting up or down, flags the final iteration and pulses done.
module iter_counter
    import iter_counter_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          COUNT_DOWN = 1'b0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] lim_m1;
    logic             term;
    logic             lim_load;
    logic             cnt_load;
    logic             cnt_step;
    logic [WIDTH-1:0] cnt_value;

    updn_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .ena   (ena),
        .load  (cnt_load),
        .value (cnt_value),
        .step  (cnt_step),
        .down  (COUNT_DOWN),
        .count (count)
    );

    // Terminal compare; lim_q-1 is only formed for a non-zero limit, and the
    // compare is evaluated before any step so the count never wraps.
    always_comb begin
        lim_m1 = '0;
        if (lim_q != '0) begin
            lim_m1 = lim_q - WIDTH'(1);
        end
        if (COUNT_DOWN) begin
            term = (count == '0);
        end else begin
            term = (count == lim_m1);
        end
    end

    // Next-state and counter control; abort overrides everything else.
    always_comb begin
        state_nxt = state;
        lim_load  = 1'b0;
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;
        cnt_value = '0;
        if (abort) begin
            state_nxt = ST_IDLE;
            cnt_load  = 1'b1;
            cnt_value = '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (can_accept(state) && start) begin
                        lim_load = 1'b1;
                        if (limit == '0) begin
                            // Zero-iteration operation: straight to DONE,
                            // count left untouched.
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_RUN;
                            cnt_load  = 1'b1;
                            cnt_value = COUNT_DOWN ? (limit - WIDTH'(1)) : '0;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (term) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register, advanced only on enabled edges.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Limit register, captured only when an operation is accepted.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lim_q <= '0;
        end else if (ena && lim_load) begin
            lim_q <= limit;
        end
    end

    // Outputs are decodes of the registered state plus the terminal compare.
    always_comb begin
        busy = (state == ST_RUN);
        last = (state == ST_RUN) && term;
        done = (state == ST_DONE);
    end

endmodule : iter_counter

// File: tb/tb_iter_counter.sv
// Bench for iter_counter: an up-counting and a down-counting instance share
// stimulus; each is compared every cycle against an iteration-level model,
// with directed literal checks on top.
module tb_iter_counter;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ena;
    logic       start;
    logic       abort;
    logic [5:0] limit;

    logic [5:0] count_up, count_dn;
    logic       busy_up, last_up, done_up;
    logic       busy_dn, last_dn, done_dn;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    iter_counter #(.WIDTH(6), .COUNT_DOWN(1'b0)) dut_up (
        .clk(clk), .clrn(clrn), .ena(ena), .start(start), .abort(abort),
        .limit(limit), .count(count_up), .busy(busy_up), .last(last_up), .done(done_up)
    );

    iter_counter #(.WIDTH(6), .COUNT_DOWN(1'b1)) dut_dn (
        .clk(clk), .clrn(clrn), .ena(ena), .start(start), .abort(abort),
        .limit(limit), .count(count_dn), .busy(busy_dn), .last(last_dn), .done(done_dn)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Iteration-level model: which operation phase we are in, how many
    // iterations have completed, and the index the counter should show.
    typedef struct {
        bit          run;
        bit          fin;
        int unsigned lim;
        int unsigned iter;
        int unsigned cnt;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.run = 0; m.fin = 0; m.lim = 0; m.iter = 0; m.cnt = 0;
        return m;
    endfunction

    function automatic model_t model_next(model_t m, bit down, bit st, bit ab, int unsigned lm);
        model_t n = m;
        if (ab) begin
            n.run = 0; n.fin = 0; n.cnt = 0;
        end else if (m.run) begin
            if (m.iter == m.lim - 1) begin
                n.run = 0; n.fin = 1;
            end else begin
                n.iter = m.iter + 1;
                n.cnt  = down ? (m.lim - 1 - n.iter) : n.iter;
            end
        end else if (st) begin
            n.lim  = lm;
            n.iter = 0;
            n.fin  = (lm == 0);
            n.run  = (lm != 0);
            if (lm != 0) n.cnt = down ? (lm - 1) : 0;
        end else begin
            n.fin = 0;
        end
        return n;
    endfunction

    function automatic bit model_last(model_t m);
        return m.run && (m.iter == m.lim - 1);
    endfunction

    model_t m_up = model_reset();
    model_t m_dn = model_reset();

    // Model advance on the same edges the design sees.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_up = model_reset();
            m_dn = model_reset();
        end else if (ena) begin
            m_up = model_next(m_up, 1'b0, start, abort, limit);
            m_dn = model_next(m_dn, 1'b1, start, abort, limit);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("up.count", count_up, m_up.cnt);
        check("up.busy",  busy_up,  m_up.run);
        check("up.last",  last_up,  model_last(m_up));
        check("up.done",  done_up,  m_up.fin);
        check("dn.count", count_dn, m_dn.cnt);
        check("dn.busy",  busy_dn,  m_dn.run);
        check("dn.last",  last_dn,  model_last(m_dn));
        check("dn.done",  done_dn,  m_dn.fin);
    end

    int unsigned cycles, busy_n, last_n, edges;
    int unsigned prev_c;
    bit          prev_b, was_en, seen_done;

    initial begin
        clrn = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; limit = '0;
        repeat (2) @(negedge clk);
        check("rst.count", count_up, 0);
        check("rst.busy",  busy_up,  0);
        check("rst.done",  done_up,  0);
        clrn = 1'b1;
        @(negedge clk);

        // Up run of 32 iterations: 32 busy cycles, one last, done on the 33rd.
        start = 1'b1; limit = 6'd32;
        @(negedge clk);
        start = 1'b0;
        check("t2.first_up", count_up, 0);
        check("t2.first_dn", count_dn, 31);
        cycles = 1; busy_n = 0; last_n = 0;
        if (busy_up) busy_n++;
        while (!done_up && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (busy_up) busy_n++;
            if (last_up) begin
                last_n++;
                check("t2.last_at", count_up, 31);
            end
        end
        check("t2.latency", cycles, 33);
        check("t2.busy_n", busy_n, 32);
        check("t2.last_n", last_n, 1);
        @(negedge clk);
        check("t2.idle_busy", busy_up, 0);
        check("t2.hold_cnt", count_up, 31);

        // Down run of 4 iterations, then a zero-iteration operation.
        start = 1'b1; limit = 6'd4;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t3.dn_cnt", count_dn, 3 - k);
            check("t3.dn_last", last_dn, (k == 3) ? 1 : 0);
            if (k < 3) @(negedge clk);
        end
        @(negedge clk);
        check("t3.dn_done", done_dn, 1);
        check("t3.dn_cnt0", count_dn, 0);
        start = 1'b1; limit = 6'd0;
        @(negedge clk);
        start = 1'b0;
        check("t3.zero_done", done_dn, 1);
        check("t3.zero_busy", busy_dn, 0);
        check("t3.zero_done_up", done_up, 1);
        @(negedge clk);
        check("t3.zero_after", done_dn, 0);

        // Enable toggled every other cycle on an 8-iteration run.
        start = 1'b1; limit = 6'd8; ena = 1'b1; edges = 0;
        for (int i = 0; i < 40; i++) begin
            prev_c = count_up; prev_b = busy_up; was_en = ena;
            @(negedge clk);
            start = 1'b0;
            if (was_en) edges++;
            else begin
                check("t4.frozen_cnt", count_up, prev_c);
                check("t4.frozen_busy", busy_up, prev_b);
            end
            if (done_up) break;
            ena = ~ena;
        end
        check("t4.edges", edges, 9);
        ena = 1'b0;
        @(negedge clk);
        check("t4.done_held", done_up, 1);
        ena = 1'b1;
        @(negedge clk);
        check("t4.done_clr", done_up, 0);

        // Start in RUN is ignored; abort with start also high cancels.
        start = 1'b1; limit = 6'd20;
        @(negedge clk);
        start = 1'b0; cycles = 0; seen_done = 0;
        while (count_up != 10 && cycles < 40) begin
            if (count_up == 2) begin start = 1'b1; limit = 6'd2; end
            else start = 1'b0;
            @(negedge clk);
            cycles++;
            if (done_up) seen_done = 1;
        end
        check("t5.reach10", count_up, 10);
        check("t5.no_early_done", seen_done, 0);
        abort = 1'b1; start = 1'b1; limit = 6'd5;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("t5.abort_cnt", count_up, 0);
        check("t5.abort_cnt_dn", count_dn, 0);
        check("t5.abort_busy", busy_up, 0);
        check("t5.abort_done", done_up, 0);
        @(negedge clk);
        check("t5.after_done", done_up, 0);

        // Start held through DONE: second run follows with no idle cycle.
        start = 1'b1; limit = 6'd3; cycles = 0;
        while (!done_up && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("t6.first_lat", cycles, 4);
        limit = 6'd5;
        @(negedge clk);
        start = 1'b0;
        check("t6.b2b_cnt", count_up, 0);
        check("t6.b2b_busy", busy_up, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t6.cnt", count_up, k);
        end
        @(negedge clk);
        check("t6.done", done_up, 1);

        // Asynchronous reset in the middle of a run.
        start = 1'b1; limit = 6'd20;
        @(negedge clk);
        start = 1'b0; cycles = 0;
        while (count_up != 5 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check("t1.reach5", count_up, 5);
        #2 clrn = 1'b0;
        #1;
        check("t1.rst_cnt", count_up, 0);
        check("t1.rst_cnt_dn", count_dn, 0);
        check("t1.rst_busy", busy_up, 0);
        check("t1.rst_done", done_up, 0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        check("t1.idle_busy", busy_up, 0);
        check("t1.idle_cnt", count_up, 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_iter_counter
